// File: rtl/crane_motion_ctrl_pkg.sv
// Shared definitions for the crane motion controller: state encoding and default limits.
package crane_motion_ctrl_pkg;

    localparam int unsigned StateW = 3;

    // Encoding is also what the display sees on the state port.
    typedef enum logic [StateW-1:0] {
        StIdle    = 3'd0,
        StLower   = 3'd1,
        StGrab    = 3'd2,
        StRaise   = 3'd3,
        StReturn  = 3'd4,
        StRelease = 3'd5
    } state_e;

    localparam int unsigned DefXMax = 15;
    localparam int unsigned DefYMax = 15;
    localparam int unsigned DefZMax = 31;

endpackage

// File: rtl/crane_motion_ctrl_btn_press_edge.sv
// Two-flop synchronizer plus rising-edge detector for one debounced button.
module btn_press_edge (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic press
);

    logic [1:0] sync_q;
    logic       prev_q;

    // Synchronize the button and remember the previous synchronized level.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            prev_q <= sync_q[1];
        end
    end

    // One clock-wide event per rising edge, however long the button is held.
    assign press = sync_q[1] & ~prev_q;

endmodule

// File: rtl/crane_motion_ctrl.sv
// Crane game motion controller: joystick stepping in IDLE and the automatic
// lower/grab/raise/return/release sequence on a drop press.
module crane_motion_ctrl
    import crane_motion_ctrl_pkg::*;
#(
    parameter int unsigned X_MAX       = DefXMax,
    parameter int unsigned Y_MAX       = DefYMax,
    parameter int unsigned Z_MAX       = DefZMax,
    parameter int unsigned XY_W        = 4,
    parameter int unsigned Z_W         = 5,
    parameter int unsigned STEP_CYCLES = 1000000,
    parameter int unsigned GRAB_CYCLES = 50000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              btn_fwd,
    input  logic              btn_back,
    input  logic              btn_drop,
    output logic [XY_W-1:0]   pos_x,
    output logic [XY_W-1:0]   pos_y,
    output logic [Z_W-1:0]    pos_z,
    output logic              claw_closed,
    output logic              busy,
    output logic [StateW-1:0] state
);

    localparam int unsigned StepW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned GrabW = (GRAB_CYCLES > 1) ? $clog2(GRAB_CYCLES) : 1;

    localparam logic [StepW-1:0] StepLast = StepW'(STEP_CYCLES - 1);
    localparam logic [GrabW-1:0] GrabLast = GrabW'(GRAB_CYCLES - 1);
    localparam logic [XY_W-1:0]  XMax     = XY_W'(X_MAX);
    localparam logic [XY_W-1:0]  YMax     = XY_W'(Y_MAX);
    localparam logic [XY_W-1:0]  XyZero   = '0;
    localparam logic [XY_W-1:0]  XyOne    = XY_W'(1);
    localparam logic [Z_W-1:0]   ZMax     = Z_W'(Z_MAX);
    localparam logic [Z_W-1:0]   ZZero    = '0;
    localparam logic [Z_W-1:0]   ZOne     = Z_W'(1);

    logic [4:0] btn_vec;
    logic [4:0] press;
    logic       ev_left, ev_right, ev_fwd, ev_back, ev_drop;

    assign btn_vec = {btn_drop, btn_back, btn_fwd, btn_right, btn_left};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        btn_press_edge u_edge (
            .clock (clock),
            .reset (reset),
            .btn   (btn_vec[i]),
            .press (press[i])
        );
    end

    assign {ev_drop, ev_back, ev_fwd, ev_right, ev_left} = press;

    state_e            state_q, state_d;
    logic [XY_W-1:0]   x_q, x_d, y_q, y_d;
    logic [Z_W-1:0]    z_q, z_d;
    logic [StepW-1:0]  step_q, step_d;
    logic [GrabW-1:0]  grab_q, grab_d;
    logic              claw_q, busy_q;
    logic              tick, grab_done;

    assign tick      = (step_q == StepLast);
    assign grab_done = (grab_q == GrabLast);

    // Next-state, position and timer logic.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        unique case (state_q)
            StIdle: begin
                if (ev_drop) begin
                    state_d = StLower;
                end else begin
                    if (ev_left && !ev_right && x_q != XyZero) x_d = x_q - 1'b1;
                    if (ev_right && !ev_left && x_q < XMax)    x_d = x_q + 1'b1;
                    if (ev_back && !ev_fwd && y_q != XyZero)   y_d = y_q - 1'b1;
                    if (ev_fwd && !ev_back && y_q < YMax)      y_d = y_q + 1'b1;
                end
            end
            StLower: begin
                if (tick) begin
                    if (z_q < ZMax)         z_d = z_q + 1'b1;
                    if (z_q >= ZMax - ZOne) state_d = StGrab;
                end
            end
            StGrab: begin
                if (grab_done) state_d = StRaise;
            end
            StRaise: begin
                if (tick) begin
                    if (z_q != ZZero) z_d = z_q - 1'b1;
                    if (z_q <= ZOne)  state_d = StReturn;
                end
            end
            StReturn: begin
                // Already home on entry: release without waiting for a tick.
                if (x_q == XyZero && y_q == XyZero) begin
                    state_d = StRelease;
                end else if (tick) begin
                    if (x_q != XyZero) x_d = x_q - 1'b1;
                    if (y_q != XyZero) y_d = y_q - 1'b1;
                    if (x_q <= XyOne && y_q <= XyOne) state_d = StRelease;
                end
            end
            StRelease: begin
                if (grab_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Both timers restart on every state entry.
        step_d = '0;
        grab_d = '0;
        if (state_d == state_q) begin
            step_d = tick ? '0 : step_q + 1'b1;
            grab_d = grab_done ? '0 : grab_q + 1'b1;
        end
    end

    // State, position, timer and registered output flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            step_q  <= '0;
            grab_q  <= '0;
            claw_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            step_q  <= step_d;
            grab_q  <= grab_d;
            claw_q  <= (state_d inside {StGrab, StRaise, StReturn});
            busy_q  <= (state_d != StIdle);
        end
    end

    assign pos_x       = x_q;
    assign pos_y       = y_q;
    assign pos_z       = z_q;
    assign claw_closed = claw_q;
    assign busy        = busy_q;
    assign state       = state_q;

endmodule

// File: tb/tb_crane_motion_ctrl.sv
// Self-checking bench for crane_motion_ctrl: vector table, hand sequences and
// randomized joystick traffic against a timeline/arithmetic reference model.
module tb_crane_motion_ctrl;

    localparam int XM = 3;
    localparam int YM = 3;
    localparam int ZM = 2;
    localparam int S  = 4;
    localparam int G  = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       btn_left, btn_right, btn_fwd, btn_back, btn_drop;
    logic [3:0] pos_x, pos_y;
    logic [4:0] pos_z;
    logic       claw_closed, busy;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    crane_motion_ctrl #(
        .X_MAX       (XM),
        .Y_MAX       (YM),
        .Z_MAX       (ZM),
        .XY_W        (4),
        .Z_W         (5),
        .STEP_CYCLES (S),
        .GRAB_CYCLES (G)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_fwd     (btn_fwd),
        .btn_back    (btn_back),
        .btn_drop    (btn_drop),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .pos_z       (pos_z),
        .claw_closed (claw_closed),
        .busy        (busy),
        .state       (state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] mv;   // {left, right, fwd, back}
        int         ex;
        int         ey;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input int st, input int x, input int y,
                           input int z, input int cl);
        chk({name, "_state"}, int'(state), st);
        chk({name, "_x"}, int'(pos_x), x);
        chk({name, "_y"}, int'(pos_y), y);
        chk({name, "_z"}, int'(pos_z), z);
        chk({name, "_claw"}, int'(claw_closed), cl);
        chk({name, "_busy"}, int'(busy), (st != 0) ? 1 : 0);
    endtask

    task automatic set_btns(input logic [4:0] b);
        {btn_left, btn_right, btn_fwd, btn_back, btn_drop} = b;
    endtask

    task automatic do_reset();
        set_btns(5'b0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Raise the given joystick buttons together, hold, release and settle.
    task automatic press(input logic [3:0] mv);
        set_btns({mv, 1'b0});
        repeat (3) @(negedge clock);
        set_btns(5'b0);
        repeat (3) @(negedge clock);
    endtask

    function automatic int clamp(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    // Drop from (x0,y0) and compare every cycle against the phase timeline.
    task automatic run_seq(input int x0, input int y0, input bit noisy);
        int lw, r0, t0, d, t1, t2, est, ex, ey, ez, ec, j;
        lw = ZM * S;
        r0 = lw + G;
        t0 = r0 + lw;
        d  = (x0 == 0 && y0 == 0) ? 1 : ((x0 > y0 ? x0 : y0) * S);
        t1 = t0 + d;
        t2 = t1 + G;
        btn_drop = 1'b1;
        for (int k = -2; k <= t2 + 3; k++) begin
            @(negedge clock);
            ex = 0; ey = 0; ez = 0; ec = 0;
            if (k < 0) begin
                est = 0; ex = x0; ey = y0;
            end else if (k < lw) begin
                est = 1; ex = x0; ey = y0; ez = k / S;
            end else if (k < r0) begin
                est = 2; ex = x0; ey = y0; ez = ZM; ec = 1;
            end else if (k < t0) begin
                est = 3; ex = x0; ey = y0; ez = ZM - (k - r0) / S; ec = 1;
            end else if (k < t1) begin
                est = 4; j = (k - t0) / S;
                ex = clamp(x0 - j, XM); ey = clamp(y0 - j, YM); ec = 1;
            end else if (k < t2) begin
                est = 5;
            end else begin
                est = 0;
            end
            chk_all(noisy ? "seq_noisy" : "seq", est, ex, ey, ez, ec);
            if (noisy && k >= 0 && k + 4 < t2) set_btns(5'($urandom));
            else set_btns(5'b0);
        end
    endtask

    initial begin
        logic [3:0] prev_lvl, lvl, ev, mask;
        logic [3:0] evq[$];
        int mx, my;

        tbl[0]  = '{4'b0100, 1, 0};
        tbl[1]  = '{4'b0100, 2, 0};
        tbl[2]  = '{4'b0100, 3, 0};
        tbl[3]  = '{4'b0100, 3, 0};
        tbl[4]  = '{4'b1100, 3, 0};
        tbl[5]  = '{4'b0010, 3, 1};
        tbl[6]  = '{4'b0001, 3, 0};
        tbl[7]  = '{4'b0001, 3, 0};
        tbl[8]  = '{4'b1010, 2, 1};
        tbl[9]  = '{4'b1110, 2, 2};
        tbl[10] = '{4'b0010, 2, 3};
        tbl[11] = '{4'b0010, 2, 3};
        tbl[12] = '{4'b0011, 2, 3};
        tbl[13] = '{4'b1111, 2, 3};
        tbl[14] = '{4'b1000, 1, 3};
        tbl[15] = '{4'b0101, 2, 2};
        tbl[16] = '{4'b1000, 1, 2};
        tbl[17] = '{4'b1000, 0, 2};
        tbl[18] = '{4'b1000, 0, 2};

        // Reset state.
        do_reset();
        chk_all("reset", 0, 0, 0, 0, 0);

        // Held right button: exactly one step, two edges after the rise.
        btn_right = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("hold_right_x", int'(pos_x), (i >= 2) ? 1 : 0);
        end
        set_btns(5'b0);
        repeat (3) @(negedge clock);

        // Vector table from home.
        do_reset();
        for (int i = 0; i < 19; i++) begin
            press(tbl[i].mv);
            chk("tbl_x", int'(pos_x), tbl[i].ex);
            chk("tbl_y", int'(pos_y), tbl[i].ey);
            chk("tbl_state", int'(state), 0);
        end

        // Randomized joystick traffic vs. delayed saturating-arithmetic model.
        do_reset();
        mx = 0; my = 0; prev_lvl = 4'b0;
        evq = {4'b0, 4'b0, 4'b0};
        for (int it = 0; it < 400; it++) begin
            @(negedge clock);
            ev = evq.pop_front();
            mx = clamp(mx + int'(ev[2]) - int'(ev[3]), XM);
            my = clamp(my + int'(ev[1]) - int'(ev[0]), YM);
            chk("rand_x", int'(pos_x), mx);
            chk("rand_y", int'(pos_y), my);
            for (int b = 0; b < 4; b++) mask[b] = ($urandom_range(3) == 0);
            lvl = (it >= 396) ? 4'b0 : (prev_lvl ^ mask);
            evq.push_back(lvl & ~prev_lvl);
            set_btns({lvl, 1'b0});
            prev_lvl = lvl;
        end

        // Full sequence from (2,1) with discarded button noise while busy.
        do_reset();
        press(4'b0100);
        press(4'b0100);
        press(4'b0010);
        chk("pre_seq_x", int'(pos_x), 2);
        chk("pre_seq_y", int'(pos_y), 1);
        run_seq(2, 1, 1'b1);

        // Drop from home: RETURN lasts one cycle.
        run_seq(0, 0, 1'b0);

        // Reset pulse in the middle of GRAB.
        do_reset();
        btn_drop = 1'b1;
        for (int k = -2; k <= ZM * S + 2; k++) begin
            @(negedge clock);
            btn_drop = 1'b0;
        end
        chk("mid_grab_state", int'(state), 2);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk_all("grab_reset", 0, 0, 0, 0, 0);
        press(4'b0100);
        chk("after_reset_x", int'(pos_x), 1);
        chk("after_reset_state", int'(state), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
